// File: rtl/wb_pkg.sv
// wb_pkg -- shared types and constants for the writeback stage.
//
// Contents:
//   wb_sel_e     writeback source select (ALU / MEM / PC4; 2'b11 is reserved)
//   F3_*         load funct3 encodings (size and signedness)
//   wb_entry_t   control half of the one-entry MEM/WB register; the
//                width-parametric fields (rd, alu, mem, pc) are held beside it
//   align_mask   low-address bits that must be zero for a given load size
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    // wb_sel is kept as raw bits so the reserved encoding survives capture.
    typedef struct packed {
        logic       valid;
        logic [1:0] wb_sel;
        logic       rd_en;
        logic [2:0] funct3;
    } wb_entry_t;

    // Address bits that must be clear for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [2:0] f3);
        logic [2:0] m;
        case (f3)
            F3_LH, F3_LHU: m = 3'b001;
            F3_LW, F3_LWU: m = 3'b011;
            F3_LD:         m = 3'b111;
            default:       m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/wb_stage_load_ext.sv
// load_ext -- combinational load alignment and sign/zero extension.
//
// Parameters: XLEN (32/64), AW = log2(XLEN/8) byte-lane address bits.
// Ports:
//   funct3    in   load size/sign encoding (F3_*)
//   addr      in   low address bits selecting the byte lane
//   mem_data  in   raw aligned memory word
//   ext_data  out  lane-shifted, extended load value
//   misalign  out  access is not naturally aligned (not gated by valid/wb_sel)
module load_ext
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 2
) (
    input  logic [2:0]      funct3,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] mem_data,
    output logic [XLEN-1:0] ext_data,
    output logic            misalign
);

    // Keep the low nbits of v and fill the rest with the given fill bit.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                               input int unsigned nbits,
                                               input logic fill);
        logic [XLEN-1:0] r;
        for (int unsigned i = 0; i < XLEN; i++) begin
            if (i < nbits) begin
                r[i] = v[i];
            end else begin
                r[i] = fill;
            end
        end
        return r;
    endfunction

    logic [XLEN-1:0] shifted_s;
    logic [2:0]      addr3_s;

    // Move the addressed byte lane down to bit 0, then extend by size/sign.
    always_comb begin
        shifted_s = mem_data >> {addr, 3'b000};
        addr3_s   = 3'(addr);
        case (funct3)
            F3_LB:   ext_data = extend(shifted_s, 32'd8,  shifted_s[7]);
            F3_LH:   ext_data = extend(shifted_s, 32'd16, shifted_s[15]);
            F3_LW:   ext_data = extend(shifted_s, 32'd32, shifted_s[31]);
            F3_LBU:  ext_data = extend(shifted_s, 32'd8,  1'b0);
            F3_LHU:  ext_data = extend(shifted_s, 32'd16, 1'b0);
            F3_LWU:  ext_data = extend(shifted_s, 32'd32, 1'b0);
            F3_LD:   ext_data = shifted_s;
            default: ext_data = mem_data;
        endcase
        misalign = |(addr3_s & align_mask(funct3));
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage -- one-entry MEM/WB register plus writeback source selection.
//
// Holds one entry from the memory stage, selects ALU result, extended load
// data or PC+4, and drives the register-file write port. rf_* outputs are
// combinational from the held entry (one cycle after capture).
//
// Optional feature: define WB_RETIRE_CNT_EN to build the retire counter and
// its retire_cnt port; without it the port and counter are absent.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   in_valid / in_ready   MEM-stage handshake (in_ready = !stall)
//   stall, flush          hold entry / kill entry (flush wins)
//   wb_sel, rd_en, rd, funct3, alu_data, mem_data, pc   entry fields
//   rf_we, rf_rd, rf_wdata                 register-file write port
//   fwd_valid                              forwarding tap (= rf_we)
//   misalign                               held load misaligned, write blocked
//   retire_cnt                             retired count (WB_RETIRE_CNT_EN)
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        wb_sel,
    input  logic              rd_en,
    input  logic [REG_AW-1:0] rd,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   alu_data,
    input  logic [XLEN-1:0]   mem_data,
    input  logic [XLEN-1:0]   pc,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              fwd_valid,
    output logic              misalign
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]  retire_cnt
`endif
);

    localparam int unsigned   LANE_W  = $clog2(XLEN / 8);
    localparam logic [XLEN-1:0]   PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0]   XZERO   = {XLEN{1'b0}};
    localparam logic [REG_AW-1:0] RZERO   = {REG_AW{1'b0}};

    // Parameter sanity hook: an elaboration-visible guard with no logic.
    if (CNT_W < 1 || (XLEN != 32 && XLEN != 64)) begin : g_bad_params
    end

    wb_entry_t         entry_q, entry_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   alu_q, alu_d;
    logic [XLEN-1:0]   mem_q, mem_d;
    logic [XLEN-1:0]   pc_q, pc_d;

    logic [XLEN-1:0]   ext_data_s;
    logic              ext_misalign_s;
    logic              misalign_s;
    logic [XLEN-1:0]   wb_data_s;
    logic              we_s;

    // Next-state for the held entry: flush > stall (hold) > capture > bubble.
    always_comb begin
        entry_d = entry_q;
        rd_d    = rd_q;
        alu_d   = alu_q;
        mem_d   = mem_q;
        pc_d    = pc_q;
        if (flush) begin
            entry_d.valid = 1'b0;
        end else if (stall) begin
            entry_d = entry_q;
        end else if (in_valid) begin
            entry_d.valid  = 1'b1;
            entry_d.wb_sel = wb_sel;
            entry_d.rd_en  = rd_en;
            entry_d.funct3 = funct3;
            rd_d           = rd;
            alu_d          = alu_data;
            mem_d          = mem_data;
            pc_d           = pc;
        end else begin
            entry_d.valid = 1'b0;
        end
    end

    // Control register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    // Data fields carry no reset; outputs are gated by valid instead.
    always_ff @(posedge clk) begin
        rd_q  <= rd_d;
        alu_q <= alu_d;
        mem_q <= mem_d;
        pc_q  <= pc_d;
    end

    load_ext #(
        .XLEN (XLEN),
        .AW   (LANE_W)
    ) u_load_ext (
        .funct3   (entry_q.funct3),
        .addr     (alu_q[LANE_W-1:0]),
        .mem_data (mem_q),
        .ext_data (ext_data_s),
        .misalign (ext_misalign_s)
    );

    // Writeback source select and register-file port.
    always_comb begin
        case (entry_q.wb_sel)
            WB_ALU:  wb_data_s = alu_q;
            WB_MEM:  wb_data_s = ext_data_s;
            WB_PC4:  wb_data_s = pc_q + PC_STEP;
            default: wb_data_s = alu_q;
        endcase
        misalign_s = entry_q.valid && (entry_q.wb_sel == WB_MEM) && ext_misalign_s;
        // x0 is hardwired zero, so writes to it are dropped here.
        we_s = entry_q.valid && entry_q.rd_en && (rd_q != RZERO) && !misalign_s;

        in_ready  = !stall;
        rf_we     = we_s;
        fwd_valid = we_s;
        misalign  = misalign_s;
        if (entry_q.valid) begin
            rf_rd    = rd_q;
            rf_wdata = wb_data_s;
        end else begin
            rf_rd    = RZERO;
            rf_wdata = XZERO;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    // An entry retires when it leaves the register unstalled.
    always_comb begin
        if (entry_q.valid && !stall) begin
            retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retire_cnt_d = retire_cnt_q;
        end
    end

    // Retire counter register, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_q <= {CNT_W{1'b0}};
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule
